// File: rtl/komut_bellegi.sv
// Instruction memory for the genc core: byte-wise program upload, core reset hold, fetch fault flag.
// Optional trailing checksum word enabled by defining KOMUT_BELLEGI_SAGLAMA_EN.
module komut_bellegi #(
    parameter int unsigned DERINLIK  = 64,
    parameter logic [31:0] BOS_KOMUT = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          yukle_basla,
    input  logic [$clog2(DERINLIK):0]     kelime_sayisi,
    input  logic [7:0]                    veri,
    input  logic                          veri_gecerli,
    output logic                          veri_hazir,
    input  logic [31:0]                   pc,
    output logic [31:0]                   komut,
    output logic                          cekirdek_reset,
    output logic                          yuklendi,
    output logic                          hata
);

    localparam int unsigned AW  = $clog2(DERINLIK);
    localparam int unsigned NW  = AW + 1;
    localparam logic [31:0] UST = 32'(4 * DERINLIK);

    typedef enum logic [2:0] {
        BOS   = 3'd0,
        YUKLE = 3'd1,
        CALIS = 3'd2,
        HATA  = 3'd3
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
        , SAGLAMA = 3'd4
`endif
    } durum_t;

    durum_t        durum_q, durum_d;
    logic [NW-1:0] n_q;
    logic [AW-1:0] w_q;
    logic [1:0]    k_q;
    logic [23:0]   tampon_q;
    logic          calis_q, hata_q;
    logic          hazir_d, calis_d, hata_d;
    logic [31:0]   mem [DERINLIK];

    logic          kabul, basla_ok, son_kelime, yukle_al, getir_ok;
    logic [31:0]   kelime;

    assign kabul      = veri_gecerli && veri_hazir;
    assign kelime     = {veri, tampon_q};
    assign basla_ok   = (kelime_sayisi != '0) && (kelime_sayisi <= NW'(DERINLIK));
    assign son_kelime = (NW'(w_q) == (n_q - NW'(1)));
    assign yukle_al   = yukle_basla && ((durum_q == BOS) || (durum_q == CALIS));

`ifdef KOMUT_BELLEGI_SAGLAMA_EN
    logic [31:0] toplam_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) durum_q <= BOS;
        else        durum_q <= durum_d;
    end

    // Next-state logic
    always_comb begin
        durum_d = durum_q;
        unique case (durum_q)
            BOS, CALIS: if (yukle_basla) durum_d = basla_ok ? YUKLE : HATA;
            YUKLE: if (kabul && (k_q == 2'd3) && son_kelime) begin
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
                durum_d = SAGLAMA;
`else
                durum_d = CALIS;
`endif
            end
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
            SAGLAMA: if (kabul && (k_q == 2'd3)) durum_d = (kelime == toplam_q) ? CALIS : HATA;
`endif
            HATA:    durum_d = HATA;
            default: durum_d = BOS;
        endcase
    end

    // Output decode of the next state, registered below so outputs track the state register
    always_comb begin
        hazir_d = (durum_d == YUKLE);
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
        hazir_d = hazir_d || (durum_d == SAGLAMA);
`endif
        calis_d = (durum_d == CALIS);
        hata_d  = (durum_d == HATA);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            veri_hazir <= 1'b0;
            calis_q    <= 1'b0;
            hata_q     <= 1'b0;
        end else begin
            veri_hazir <= hazir_d;
            calis_q    <= calis_d;
            hata_q     <= hata_d;
        end
    end

    // Upload counters and partial-word assembly
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_q      <= '0;
            w_q      <= '0;
            k_q      <= '0;
            tampon_q <= '0;
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
            toplam_q <= '0;
`endif
        end else if (yukle_al) begin
            n_q <= kelime_sayisi;
            w_q <= '0;
            k_q <= '0;
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
            toplam_q <= '0;
`endif
        end else if (kabul) begin
            k_q <= k_q + 2'd1;
            unique case (k_q)
                2'd0: tampon_q[7:0]   <= veri;
                2'd1: tampon_q[15:8]  <= veri;
                2'd2: tampon_q[23:16] <= veri;
                default: begin
                    if (durum_q == YUKLE) begin
                        w_q <= w_q + AW'(1);
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
                        toplam_q <= toplam_q + kelime;
`endif
                    end
                end
            endcase
        end
    end

    // Loader write port; the checksum word never reaches memory
    always_ff @(posedge clk) begin
        if (reset && kabul && (durum_q == YUKLE) && (k_q == 2'd3)) mem[w_q] <= kelime;
    end

    assign cekirdek_reset = calis_q;
    assign yuklendi       = calis_q;

    // Asynchronous fetch port
    assign getir_ok = (pc[1:0] == 2'b00) && (pc < UST);
    assign komut    = (calis_q && getir_ok) ? mem[pc[AW+1:2]] : BOS_KOMUT;
    assign hata     = hata_q || (calis_q && !getir_ok);

endmodule

// File: tb/tb_komut_bellegi.sv
// Scoreboard bench for komut_bellegi: upload, fetch, fault and reset scenarios.
module tb_komut_bellegi;

    localparam int unsigned DERINLIK = 64;
    localparam int unsigned NW       = $clog2(DERINLIK) + 1;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          yukle_basla;
    logic [NW-1:0] kelime_sayisi;
    logic [7:0]    veri;
    logic          veri_gecerli;
    logic          veri_hazir;
    logic [31:0]   pc;
    logic [31:0]   komut;
    logic          cekirdek_reset;
    logic          yuklendi;
    logic          hata;

    always #5 clk = ~clk;

    komut_bellegi #(.DERINLIK(DERINLIK)) dut (
        .clk(clk), .reset(reset), .yukle_basla(yukle_basla), .kelime_sayisi(kelime_sayisi),
        .veri(veri), .veri_gecerli(veri_gecerli), .veri_hazir(veri_hazir), .pc(pc),
        .komut(komut), .cekirdek_reset(cekirdek_reset), .yuklendi(yuklendi), .hata(hata)
    );

    typedef struct packed {
        logic        hata;
        logic [31:0] komut;
    } beklenen_t;

    beklenen_t   sb_q[$];
    logic [31:0] mdl [DERINLIK];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic kontrol(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    task automatic start(input logic [NW-1:0] n);
        kelime_sayisi = n;
        yukle_basla   = 1'b1;
        tick();
        yukle_basla   = 1'b0;
    endtask

    // Offer one byte until the block takes it, bounded
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit alindi;
        alindi = 1'b0;
        if (gap) begin
            veri_gecerli = 1'b0;
            tick();
        end
        veri         = b;
        veri_gecerli = 1'b1;
        for (int i = 0; i < 20 && !alindi; i++) begin
            if (veri_hazir) alindi = 1'b1;
            tick();
        end
        veri_gecerli = 1'b0;
        if (!alindi) kontrol("byte_timeout", 32'(alindi), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic finish_load(input logic [31:0] s, input bit gap);
`ifdef KOMUT_BELLEGI_SAGLAMA_EN
        send_word(s, gap);
`else
        if (gap && s == 32'hFFFF_FFFF) tick();
`endif
    endtask

    // Drive pc, push the expectation, then pop and compare the combinational response
    task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] ek, input logic eh);
        beklenen_t b;
        pc = a;
        sb_q.push_back({eh, ek});
        #2;
        b = sb_q.pop_front();
        kontrol({tag, "_komut"}, komut, b.komut);
        kontrol({tag, "_hata"}, 32'(hata), 32'(b.hata));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; yukle_basla = 1'b0; kelime_sayisi = '0;
        veri = '0; veri_gecerli = 1'b0; pc = '0;

        // 1: reset state
        repeat (2) tick();
        kontrol("rst_hazir", 32'(veri_hazir), 32'd0);
        kontrol("rst_creset", 32'(cekirdek_reset), 32'd0);
        kontrol("rst_yuklendi", 32'(yuklendi), 32'd0);
        kontrol("rst_hata", 32'(hata), 32'd0);
        kontrol("rst_komut", komut, NOP);
        reset = 1'b1;
        tick();

        // 2: two-word upload with gaps
        mdl[0] = 32'h0010_0093;
        mdl[1] = 32'h0020_0113;
        start(NW'(2));
        kontrol("y_hazir", 32'(veri_hazir), 32'd1);
        kontrol("y_creset", 32'(cekirdek_reset), 32'd0);
        fetch("y_fetch", 32'd0, NOP, 1'b0);
        send_word(mdl[0], 1'b1);
        kontrol("mid_creset", 32'(cekirdek_reset), 32'd0);
        send_word(mdl[1], 1'b1);
        finish_load(mdl[0] + mdl[1], 1'b1);
        kontrol("done_creset", 32'(cekirdek_reset), 32'd1);
        kontrol("done_yuklendi", 32'(yuklendi), 32'd1);
        kontrol("done_hazir", 32'(veri_hazir), 32'd0);
        fetch("pc4", 32'd4, mdl[1], 1'b0);
        fetch("pc0", 32'd0, mdl[0], 1'b0);

        // 3: fetch faults in CALIS
        fetch("pc2", 32'd2, NOP, 1'b1);
        fetch("pc_top", 32'(4 * DERINLIK), NOP, 1'b1);
        fetch("pc_max", 32'hFFFF_FFFC, NOP, 1'b1);
        fetch("pc0b", 32'd0, mdl[0], 1'b0);

        // Reload from CALIS holds the core in reset again
        start(NW'(1));
        kontrol("rl_creset", 32'(cekirdek_reset), 32'd0);
        kontrol("rl_hazir", 32'(veri_hazir), 32'd1);
        kontrol("rl_yuklendi", 32'(yuklendi), 32'd0);
        fetch("rl_fetch", 32'd4, NOP, 1'b0);
        mdl[0] = 32'hCAFE_F00D;
        send_word(mdl[0], 1'b0);
        finish_load(mdl[0], 1'b0);
        kontrol("rl_done", 32'(cekirdek_reset), 32'd1);
        fetch("rl_pc0", 32'd0, mdl[0], 1'b0);
        fetch("rl_pc4", 32'd4, mdl[1], 1'b0);

        // 4: out-of-range word counts
        do_reset(1);
        start(NW'(0));
        kontrol("n0_hata", 32'(hata), 32'd1);
        kontrol("n0_hazir", 32'(veri_hazir), 32'd0);
        kontrol("n0_creset", 32'(cekirdek_reset), 32'd0);
        fetch("n0_fetch", 32'd0, NOP, 1'b1);
        start(NW'(1));
        tick();
        kontrol("n0_sticky", 32'(hata), 32'd1);
        kontrol("n0_sticky_hazir", 32'(veri_hazir), 32'd0);
        do_reset(2);
        kontrol("n0_clr", 32'(hata), 32'd0);
        start(NW'(DERINLIK + 1));
        kontrol("nbig_hata", 32'(hata), 32'd1);
        kontrol("nbig_hazir", 32'(veri_hazir), 32'd0);
        do_reset(1);
        start(NW'(DERINLIK));
        kontrol("nmax_hata", 32'(hata), 32'd0);
        kontrol("nmax_hazir", 32'(veri_hazir), 32'd1);
        do_reset(1);

        // 5: reset in the middle of an upload, then a fresh one-word load
        start(NW'(2));
        for (int i = 0; i < 5; i++) send_byte(8'((i + 1) * 8'h11), 1'b0);
        reset = 1'b0;
        tick();
        kontrol("mid_rst_hazir", 32'(veri_hazir), 32'd0);
        kontrol("mid_rst_hata", 32'(hata), 32'd0);
        reset = 1'b1;
        mdl[0] = 32'hDEAD_BEEF;
        start(NW'(1));
        send_word(mdl[0], 1'b1);
        finish_load(mdl[0], 1'b1);
        kontrol("n1_creset", 32'(cekirdek_reset), 32'd1);
        fetch("n1_pc0", 32'd0, mdl[0], 1'b0);
        fetch("n1_pc4", 32'd4, mdl[1], 1'b0);

`ifdef KOMUT_BELLEGI_SAGLAMA_EN
        // 6: checksum accept and reject
        do_reset(1);
        mdl[0] = 32'h0010_0093;
        mdl[1] = 32'h0020_0113;
        start(NW'(2));
        send_word(mdl[0], 1'b1);
        send_word(mdl[1], 1'b1);
        kontrol("sg_wait_creset", 32'(cekirdek_reset), 32'd0);
        kontrol("sg_wait_hazir", 32'(veri_hazir), 32'd1);
        send_word(32'h0030_01A6, 1'b1);
        kontrol("sg_ok_creset", 32'(cekirdek_reset), 32'd1);
        fetch("sg_pc4", 32'd4, mdl[1], 1'b0);
        do_reset(1);
        start(NW'(2));
        send_word(mdl[0], 1'b1);
        send_word(mdl[1], 1'b1);
        send_word(32'h0030_01A7, 1'b1);
        kontrol("sg_bad_hata", 32'(hata), 32'd1);
        kontrol("sg_bad_creset", 32'(cekirdek_reset), 32'd0);
`endif

        if (sb_q.size() != 0) kontrol("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
